// File: rtl/regfile_writeback_arbiter.sv
// Writeback arbiter for the CR16 register file: merges ALU results and load
// returns onto the single write port and tracks outstanding loads per register.
module regfile_writeback_arbiter #(
    parameter int WIDTH         = 16,
    parameter int REGISTER_BITS = 4,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          aluValid,
    input  logic [REGISTER_BITS-1:0]      aluAddress,
    input  logic [WIDTH-1:0]              aluData,
    input  logic                          memValid,
    output logic                          memReady,
    input  logic [REGISTER_BITS-1:0]      memAddress,
    input  logic [WIDTH-1:0]              memData,
    input  logic                          loadIssue,
    input  logic [REGISTER_BITS-1:0]      loadIssueAddress,
    output logic                          shouldWrite,
    output logic [REGISTER_BITS-1:0]      writeAddress,
    output logic [WIDTH-1:0]              writeData,
    output logic [(1<<REGISTER_BITS)-1:0] registerBusy,
    output logic                          wawError
);

    localparam int NREGS = 1 << REGISTER_BITS;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REGISTER_BITS-1:0] r_fifo_addr [FIFO_DEPTH];
    logic [WIDTH-1:0]         r_fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_count;
    logic                     r_should_write;
    logic [REGISTER_BITS-1:0] r_write_address;
    logic [WIDTH-1:0]         r_write_data;
    logic [NREGS-1:0]         r_busy;
    logic                     r_waw;

    logic                     w_empty;
    logic                     w_accept;
    logic                     w_pop;
    logic                     w_bypass;
    logic                     w_push;
    logic                     w_sel_valid;
    logic                     w_mem_emit;
    logic [REGISTER_BITS-1:0] w_sel_addr;
    logic [WIDTH-1:0]         w_sel_data;
    logic [NREGS-1:0]         w_busy_next;
    logic                     w_waw_hit;

    // Ready depends only on the registered count, so a same-cycle pop never raises it.
    assign memReady = (r_count < CNT_W'(FIFO_DEPTH));
    assign w_empty  = (r_count == {CNT_W{1'b0}});
    assign w_accept = memValid && memReady;

    assign shouldWrite  = r_should_write;
    assign writeAddress = r_write_address;
    assign writeData    = r_write_data;
    assign registerBusy = r_busy;
    assign wawError     = r_waw;

    // Source selection: ALU first, then buffered loads, then a direct bypass.
    always_comb begin
        w_pop       = 1'b0;
        w_bypass    = 1'b0;
        w_sel_valid = 1'b0;
        w_mem_emit  = 1'b0;
        w_sel_addr  = r_write_address;
        w_sel_data  = r_write_data;
        if (aluValid) begin
            w_sel_valid = 1'b1;
            w_sel_addr  = aluAddress;
            w_sel_data  = aluData;
        end else if (!w_empty) begin
            w_pop       = 1'b1;
            w_sel_valid = 1'b1;
            w_mem_emit  = 1'b1;
            w_sel_addr  = r_fifo_addr[r_rd_ptr];
            w_sel_data  = r_fifo_data[r_rd_ptr];
        end else if (w_accept) begin
            w_bypass    = 1'b1;
            w_sel_valid = 1'b1;
            w_mem_emit  = 1'b1;
            w_sel_addr  = memAddress;
            w_sel_data  = memData;
        end else begin
            w_sel_valid = 1'b0;
        end
        w_push = w_accept && !w_bypass;
    end

    // Scoreboard update; a new issue to the same register overrides the retiring clear.
    always_comb begin
        w_busy_next = r_busy;
        if (w_mem_emit) begin
            w_busy_next[w_sel_addr] = 1'b0;
        end else begin
            w_busy_next = r_busy;
        end
        if (loadIssue) begin
            w_busy_next[loadIssueAddress] = 1'b1;
        end else begin
            w_busy_next[0] = 1'b0;
        end
        w_busy_next[0] = 1'b0;
    end

    assign w_waw_hit = aluValid && (aluAddress != {REGISTER_BITS{1'b0}}) && r_busy[aluAddress];

    // Load-return FIFO storage; data entries need no reset since count gates their use.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= memAddress;
            r_fifo_data[r_wr_ptr] <= memData;
        end else begin
            r_fifo_addr[r_wr_ptr] <= r_fifo_addr[r_wr_ptr];
            r_fifo_data[r_wr_ptr] <= r_fifo_data[r_wr_ptr];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= {PTR_W{1'b0}};
            r_wr_ptr <= {PTR_W{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end else begin
                r_wr_ptr <= r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end else begin
                r_rd_ptr <= r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Register-file write port; register 0 is hardwired zero so its writes are suppressed.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_should_write  <= 1'b0;
            r_write_address <= {REGISTER_BITS{1'b0}};
            r_write_data    <= {WIDTH{1'b0}};
        end else if (w_sel_valid) begin
            r_should_write  <= (w_sel_addr != {REGISTER_BITS{1'b0}});
            r_write_address <= w_sel_addr;
            r_write_data    <= w_sel_data;
        end else begin
            r_should_write  <= 1'b0;
            r_write_address <= r_write_address;
            r_write_data    <= r_write_data;
        end
    end

    // Scoreboard and sticky WAW flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= {NREGS{1'b0}};
            r_waw  <= 1'b0;
        end else begin
            r_busy <= w_busy_next;
            r_waw  <= r_waw || w_waw_hit;
        end
    end

endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: a vector table for single-cycle
// behaviour plus hand sequences for backpressure, WAW and asynchronous reset.
module tb_regfile_writeback_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        aluValid;
    logic [3:0]  aluAddress;
    logic [15:0] aluData;
    logic        memValid;
    logic        memReady;
    logic [3:0]  memAddress;
    logic [15:0] memData;
    logic        loadIssue;
    logic [3:0]  loadIssueAddress;
    logic        shouldWrite;
    logic [3:0]  writeAddress;
    logic [15:0] writeData;
    logic [15:0] registerBusy;
    logic        wawError;

    int checks = 0;
    int errors = 0;

    regfile_writeback_arbiter #(.WIDTH(16), .REGISTER_BITS(4), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .aluValid(aluValid), .aluAddress(aluAddress), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memAddress(memAddress), .memData(memData),
        .loadIssue(loadIssue), .loadIssueAddress(loadIssueAddress),
        .shouldWrite(shouldWrite), .writeAddress(writeAddress), .writeData(writeData),
        .registerBusy(registerBusy), .wawError(wawError)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        alu_v;
        logic [3:0]  alu_a;
        logic [15:0] alu_d;
        logic        mem_v;
        logic [3:0]  mem_a;
        logic [15:0] mem_d;
        logic        li;
        logic [3:0]  li_a;
        logic        e_sw;
        logic [3:0]  e_a;
        logic [15:0] e_d;
        logic [15:0] e_busy;
        logic        e_rdy;
        logic        e_waw;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic sw, input logic [3:0] a,
                             input logic [15:0] d, input logic [15:0] busy,
                             input logic rdy, input logic waw);
        chk({tag, ".shouldWrite"},  32'(shouldWrite),  32'(sw));
        chk({tag, ".writeAddress"}, 32'(writeAddress), 32'(a));
        chk({tag, ".writeData"},    32'(writeData),    32'(d));
        chk({tag, ".registerBusy"}, 32'(registerBusy), 32'(busy));
        chk({tag, ".memReady"},     32'(memReady),     32'(rdy));
        chk({tag, ".wawError"},     32'(wawError),     32'(waw));
    endtask

    task automatic drive(input logic av, input logic [3:0] aa, input logic [15:0] ad,
                         input logic mv, input logic [3:0] ma, input logic [15:0] md,
                         input logic li, input logic [3:0] lia);
        aluValid = av; aluAddress = aa; aluData = ad;
        memValid = mv; memAddress = ma; memData = md;
        loadIssue = li; loadIssueAddress = lia;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
    endtask

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        //            alu_v  alu_a  alu_d     mem_v  mem_a  mem_d     li     li_a   sw     a      d         busy      rdy    waw
        vecs[0]  = '{1'b1, 4'd3,  16'hBEEF, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd3,  16'hBEEF, 16'h0000, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd3,  16'hBEEF, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd5, 1'b0, 4'd3,  16'hBEEF, 16'h0020, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd3,  16'hBEEF, 16'h0020, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd5,  16'h1234, 1'b0, 4'd0, 1'b1, 4'd5,  16'h1234, 16'h0000, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 4'd2,  16'h0001, 1'b1, 4'd7,  16'h00AA, 1'b0, 4'd0, 1'b1, 4'd2,  16'h0001, 16'h0000, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd7,  16'h00AA, 16'h0000, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 4'd0,  16'h5555, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd0,  16'h5555, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b0, 4'd0,  16'h5555, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd6,  16'h0066, 1'b1, 4'd6, 1'b1, 4'd6,  16'h0066, 16'h0040, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd6,  16'h0077, 1'b0, 4'd0, 1'b1, 4'd6,  16'h0077, 16'h0000, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b1, 4'd0, 1'b0, 4'd6,  16'h0077, 16'h0000, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'd0,  16'h0F0F, 1'b1, 4'd4, 1'b0, 4'd0,  16'h0F0F, 16'h0010, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 4'd1,  16'h1111, 1'b1, 4'd4,  16'h4444, 1'b0, 4'd0, 1'b1, 4'd1,  16'h1111, 16'h0010, 1'b1, 1'b0};
        vecs[14] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'd0,  16'h0000, 1'b0, 4'd0, 1'b1, 4'd4,  16'h4444, 16'h0000, 1'b1, 1'b0};

        reset = 1'b0;
        idle();
        #12;
        check_all("reset", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_a, vecs[i].alu_d, vecs[i].mem_v,
                  vecs[i].mem_a, vecs[i].mem_d, vecs[i].li, vecs[i].li_a);
            cycle();
            check_all($sformatf("vec%0d", i), vecs[i].e_sw, vecs[i].e_a, vecs[i].e_d,
                      vecs[i].e_busy, vecs[i].e_rdy, vecs[i].e_waw);
        end

        // Backpressure: ALU held high starves the FIFO; loads held until accepted.
        drive(1'b1, 4'd1, 16'h1000, 1'b1, 4'd8, 16'h0A08, 1'b0, 4'd0);
        cycle(); check_all("bp0", 1'b1, 4'd1, 16'h1000, 16'h0000, 1'b1, 1'b0);
        drive(1'b1, 4'd1, 16'h1001, 1'b1, 4'd9, 16'h0B09, 1'b0, 4'd0);
        cycle(); check_all("bp1", 1'b1, 4'd1, 16'h1001, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'h1002, 1'b1, 4'd10, 16'h0C0A, 1'b0, 4'd0);
        cycle(); check_all("bp2", 1'b1, 4'd1, 16'h1002, 16'h0000, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 16'h1003, 1'b1, 4'd10, 16'h0C0A, 1'b0, 4'd0);
        cycle(); check_all("bp3", 1'b1, 4'd1, 16'h1003, 16'h0000, 1'b0, 1'b0);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd10, 16'h0C0A, 1'b0, 4'd0);
        cycle(); check_all("bp4", 1'b1, 4'd8, 16'h0A08, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd10, 16'h0C0A, 1'b0, 4'd0);
        cycle(); check_all("bp5", 1'b1, 4'd9, 16'h0B09, 16'h0000, 1'b1, 1'b0);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd11, 16'h0D0B, 1'b0, 4'd0);
        cycle(); check_all("bp6", 1'b1, 4'd10, 16'h0C0A, 16'h0000, 1'b1, 1'b0);
        idle();
        cycle(); check_all("bp7", 1'b1, 4'd11, 16'h0D0B, 16'h0000, 1'b1, 1'b0);
        cycle(); check_all("bp8", 1'b0, 4'd11, 16'h0D0B, 16'h0000, 1'b1, 1'b0);

        // WAW hazard: ALU writes a register with a load outstanding.
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd9);
        cycle(); check_all("waw0", 1'b0, 4'd11, 16'h0D0B, 16'h0200, 1'b1, 1'b0);
        drive(1'b1, 4'd9, 16'h9999, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
        cycle(); check_all("waw1", 1'b1, 4'd9, 16'h9999, 16'h0200, 1'b1, 1'b1);
        idle();
        cycle(); check_all("waw2", 1'b0, 4'd9, 16'h9999, 16'h0200, 1'b1, 1'b1);
        drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'd9, 16'h0909, 1'b0, 4'd0);
        cycle(); check_all("waw3", 1'b1, 4'd9, 16'h0909, 16'h0000, 1'b1, 1'b1);

        // Async reset with two buffered loads and busy bits set.
        drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000, 1'b1, 4'd12);
        cycle(); check_all("ar0", 1'b0, 4'd9, 16'h0909, 16'h1000, 1'b1, 1'b1);
        drive(1'b1, 4'd1, 16'h2000, 1'b1, 4'd12, 16'hC00C, 1'b1, 4'd13);
        cycle(); check_all("ar1", 1'b1, 4'd1, 16'h2000, 16'h3000, 1'b1, 1'b1);
        drive(1'b1, 4'd1, 16'h2001, 1'b1, 4'd13, 16'hD00D, 1'b0, 4'd0);
        cycle(); check_all("ar2", 1'b1, 4'd1, 16'h2001, 16'h3000, 1'b0, 1'b1);
        drive(1'b1, 4'd1, 16'h2002, 1'b0, 4'd0, 16'h0000, 1'b0, 4'd0);
        #2;
        reset = 1'b0;
        idle();
        #1;
        check_all("ar_async", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        #3;
        reset = 1'b1;
        cycle(); check_all("ar_rel0", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cycle(); check_all("ar_rel1", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cycle(); check_all("ar_rel2", 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_arbiter.md
Name: regfile_writeback_arbiter

Overview:
- Writeback stage sitting directly upstream of the CR16 register file (16 regs × 16 bits); owns its single write port (shouldWrite, writeAddress, writeData).
- Merges two result sources: the single-cycle ALU path (no backpressure) and the memory load-return path (valid/ready).
- Buffers load returns in a small FIFO and keeps a per-register load scoreboard, so the control unit can stall on load-use and WAW hazards.

Parameters:
- WIDTH, 16, data width of a register.
- REGISTER_BITS, 4, register address width; 1<<REGISTER_BITS registers.
- FIFO_DEPTH, 2, load-return buffer entries (power of two, ≥2).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- aluValid  input  1  ALU result present this cycle; always accepted.
- aluAddress  input  REGISTER_BITS  ALU destination register.
- aluData  input  WIDTH  ALU result.
- memValid  input  1  load-return data valid.
- memReady  output  1  arbiter can accept a load return.
- memAddress  input  REGISTER_BITS  load destination register.
- memData  input  WIDTH  load data.
- loadIssue  input  1  control unit issued a load this cycle.
- loadIssueAddress  input  REGISTER_BITS  destination of the issued load.
- shouldWrite  output  1  register-file write enable (registered).
- writeAddress  output  REGISTER_BITS  register-file write address (registered).
- writeData  output  WIDTH  register-file write data (registered).
- registerBusy  output  1<<REGISTER_BITS  scoreboard; bit i set while a load to register i is outstanding.
- wawError  output  1  sticky flag: ALU wrote a busy register.

Behaviour:
- Reset (reset=0, async): shouldWrite=0, writeAddress=0, writeData=0, FIFO empty, registerBusy=0, wawError=0, memReady=1 after release. Reset mid-operation discards all buffered loads and busy bits.
- memReady = (FIFO count < FIFO_DEPTH), from registered count only; a same-cycle pop does not raise it. A load is accepted when memValid && memReady.
- Per-cycle output selection, registered on the next edge, priority order:
  1. aluValid: emit the ALU result. Latency 1.
  2. FIFO non-empty: pop the head and emit it.
  3. Load accepted this cycle and FIFO empty: bypass, emit the load directly. Latency 1; the FIFO is not written.
  4. Nothing selected: shouldWrite=0; writeAddress and writeData hold.
- An accepted load not emitted by bypass is pushed to the FIFO tail. Push and pop can occur in the same cycle; count is unchanged.
- Loads retire in FIFO order and are never reordered among themselves.
- Address 0 writes are consumed (FIFO popped or ALU taken) but shouldWrite stays 0, since register 0 is hardwired zero. writeAddress and writeData still update.
- Scoreboard:
  - loadIssue with address≠0 sets registerBusy[address] on the next edge.
  - A load write emitted from the memory path clears its bit on the same edge it drives shouldWrite.
  - A set and a clear of the same bit in one cycle: set wins (a newer load is outstanding).
  - Bit 0 is always 0.
- Hazard: if aluValid and registerBusy[aluAddress]=1 (address≠0), the ALU write still proceeds, and wawError sets and stays set until reset. Upstream must stall on registerBusy to avoid this.
- Starvation is permitted: back-to-back ALU results hold off FIFO drain indefinitely; memReady then deasserts once the FIFO is full.
- Read-after-write timing: data written at edge N is visible on the register-file read ports after edge N. No forwarding in this block.

Test Plan:
- ALU only: aluValid=1, aluAddress=3, aluData=0xBEEF at cycle 0 -> cycle 1: shouldWrite=1, writeAddress=3, writeData=0xBEEF; cycle 2: shouldWrite=0.
- Load bypass and scoreboard: loadIssue to r5 at cycle 0 -> registerBusy[5]=1 at cycle 1. memValid (r5, 0x1234) at cycle 3 with ALU idle -> cycle 4: write r5=0x1234, registerBusy[5]=0.
- Contention: aluValid (r2, 0x0001) and load (r7, 0x00AA) both in cycle 0 -> cycle 1 writes r2, cycle 2 writes r7. FIFO count peaks at 1.
- Backpressure: 4 consecutive loads while aluValid held high -> memReady=0 after 2 accepted, FIFO holds 2. Drop aluValid -> loads retire in arrival order and memReady returns to 1.
- Register 0 and hazard: ALU write to r0 -> shouldWrite stays 0. loadIssue r9, then ALU write to r9 before the return -> wawError=1, held until reset.
- Async reset with 2 buffered loads and busy bits set -> all outputs cleared immediately without a clock edge; no stale write after release.
